// File: rtl/prio_encode_rr.sv
// prio_encode_rr: registered N-to-log2(N) priority encoder with valid/ack handshake and fixed or round-robin priority
module prio_encode_rr #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] x,
  input  logic         ack,
  output logic [W-1:0] y,
  output logic         valid,
  output logic         multi,
  output logic [W:0]   cnt,
  output logic [W-1:0] ptr
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, nstate;
  logic cap, found;
  logic [W-1:0] nptr, win;
  logic [W:0] pc;
  assign valid = (state == HOLD);
  always_comb begin
    cap = en && (|x) && (!valid || ack);
    nptr = (valid && ack && mode) ? ((y == W'(N-1)) ? '0 : y + 1'b1) : ptr;
    nstate = cap ? HOLD : (valid && ack) ? IDLE : state;
    win = '0;
    found = 1'b0;
    pc = '0;
    // round-robin scans from the post-acknowledge pointer so back-to-back grants rotate
    for (int i = 0; i < N; i++) begin
      int j;
      j = int'(nptr) + i;
      if (j >= N) j = j - N;
      pc = pc + (W+1)'(x[i]);
      if (!mode && x[i]) win = W'(i);
      if (mode && !found && x[j]) begin
        win = W'(j);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      y <= '0;
      cnt <= '0;
      multi <= 1'b0;
      ptr <= '0;
    end else begin
      state <= nstate;
      ptr <= nptr;
      if (cap) begin
        y <= win;
        cnt <= pc;
        multi <= (pc > (W+1)'(1));
      end
    end
  end
endmodule

// File: tb/tb_prio_encode_rr.sv
// tb_prio_encode_rr: directed checks of prio_encode_rr at N=8 and N=5
module tb_prio_encode_rr;
  logic clk = 1'b0;
  logic rst, en, mode, ack;
  logic [7:0] x8;
  logic [4:0] x5;
  logic [2:0] y8, ptr8, y5, ptr5;
  logic [3:0] cnt8, cnt5;
  logic valid8, multi8, valid5, multi5;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  prio_encode_rr #(.N(8)) u8 (.clk(clk), .rst(rst), .en(en), .mode(mode), .x(x8), .ack(ack),
    .y(y8), .valid(valid8), .multi(multi8), .cnt(cnt8), .ptr(ptr8));
  prio_encode_rr #(.N(5)) u5 (.clk(clk), .rst(rst), .en(en), .mode(mode), .x(x5), .ack(ack),
    .y(y5), .valid(valid5), .multi(multi5), .cnt(cnt5), .ptr(ptr5));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int ys[5] = '{0, 2, 7, 0, 2};
    int ps[5] = '{0, 1, 3, 0, 1};
    rst = 1; en = 1; mode = 0; ack = 0; x8 = 8'hFF; x5 = '0;
    step(); step();
    chk("rst_y", y8, 0); chk("rst_valid", valid8, 0); chk("rst_cnt", cnt8, 0);
    chk("rst_multi", multi8, 0); chk("rst_ptr", ptr8, 0);
    rst = 0;
    step();
    chk("first_y", y8, 7); chk("first_valid", valid8, 1); chk("first_cnt", cnt8, 8); chk("first_multi", multi8, 1);
    ack = 1;
    for (int i = 0; i < 8; i++) begin
      x8 = 8'(1 << i);
      step();
      chk("sweep_y", y8, i); chk("sweep_valid", valid8, 1); chk("sweep_multi", multi8, 0); chk("sweep_cnt", cnt8, 1);
    end
    x8 = 8'b0010_0110;
    step();
    chk("fix_y", y8, 5); chk("fix_cnt", cnt8, 3); chk("fix_multi", multi8, 1);
    ack = 0; x8 = 8'h80;
    step();
    chk("hold_y", y8, 5); chk("hold_valid", valid8, 1);
    ack = 1;
    step();
    chk("ack_y", y8, 7); chk("fix_ptr", ptr8, 0);
    mode = 1; x8 = 8'b1000_0101;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_y", y8, ys[i]); chk("rr_ptr", ptr8, ps[i]);
    end
    mode = 0; en = 0;
    step();
    chk("drain_valid", valid8, 0); chk("drain_ptr", ptr8, 1);
    en = 1; x8 = '0;
    step();
    chk("zero_valid", valid8, 0);
    en = 0; x8 = 8'hFF;
    step();
    chk("en0_valid", valid8, 0);
    en = 1; x8 = 8'h05; ack = 0;
    step();
    chk("mode_cap_y", y8, 2); chk("mode_cap_valid", valid8, 1);
    mode = 1;
    step();
    chk("mode_hold_y", y8, 2); chk("mode_hold_ptr", ptr8, 1);
    ack = 1;
    step();
    chk("mode_next_y", y8, 0); chk("mode_next_ptr", ptr8, 3);
    rst = 1; x8 = '0;
    step();
    rst = 0; x5 = 5'b10000;
    step();
    chk("n5_y", y5, 4); chk("n5_ptr", ptr5, 0); chk("n5_cnt", cnt5, 1);
    step();
    chk("n5_wrap_y", y5, 4); chk("n5_wrap_ptr", ptr5, 0);
    x5 = 5'b10001;
    step();
    chk("n5_b_y", y5, 0); chk("n5_b_ptr", ptr5, 0);
    step();
    chk("n5_c_y", y5, 4); chk("n5_c_ptr", ptr5, 1); chk("n5_multi", multi5, 1); chk("n5_cnt2", cnt5, 2);
    step();
    chk("n5_d_y", y5, 0); chk("n5_d_ptr", ptr5, 0);
    ack = 0;
    step();
    chk("n5_hold_valid", valid5, 1); chk("n5_hold_y", y5, 0);
    rst = 1;
    step();
    chk("mid_rst_y", y5, 0); chk("mid_rst_valid", valid5, 0); chk("mid_rst_cnt", cnt5, 0);
    chk("mid_rst_multi", multi5, 0); chk("mid_rst_ptr", ptr5, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
